// File: rtl/demux_16_bit_1x2_fifo.sv
// 1-to-2 word router: one valid/ready input stream steered by `control` into two FIFO-backed channels.
// Optional per-channel pop counters (xfer_count1/2) are enabled with `define DEMUX_XFER_COUNT_EN.
module demux_16_bit_1x2_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             control,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data1,
    output logic             out_valid1,
    input  logic             out_ready1,
    output logic [WIDTH-1:0] out_data2,
    output logic             out_valid2,
    input  logic             out_ready2
`ifdef DEMUX_XFER_COUNT_EN
    ,
    output logic [15:0]      xfer_count1,
    output logic [15:0]      xfer_count2
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Index 0 is channel 1, index 1 is channel 2.
    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [WIDTH-1:0] mem_d    [2][DEPTH];
    logic [PW-1:0]    wr_ptr_q [2];
    logic [PW-1:0]    wr_ptr_d [2];
    logic [PW-1:0]    rd_ptr_q [2];
    logic [PW-1:0]    rd_ptr_d [2];
    logic [CW-1:0]    count_q  [2];
    logic [CW-1:0]    count_d  [2];
    logic             valid_q  [2];
    logic             valid_d  [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       full;

    // Readiness looks only at registered counts, so out_ready never reaches in_ready.
    always_comb begin
        full[0]  = (count_q[0] == CNT_FULL);
        full[1]  = (count_q[1] == CNT_FULL);
        in_ready = control ? !full[1] : !full[0];
    end

    always_comb begin
        mem_d   = mem_q;
        push    = '0;
        pop     = '0;
        push[0] = in_valid && in_ready && !control;
        push[1] = in_valid && in_ready && control;
        pop[0]  = valid_q[0] && out_ready1;
        pop[1]  = valid_q[1] && out_ready2;
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_data;
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_ONE;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
            end
            if (push[i] && !pop[i]) begin
                count_d[i] = count_q[i] + CNT_ONE;
            end else if (!push[i] && pop[i]) begin
                count_d[i] = count_q[i] - CNT_ONE;
            end
            valid_d[i] = (count_d[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            count_q  <= '{default: '0};
            valid_q  <= '{default: 1'b0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Storage carries no reset; a cleared count makes stale contents unreachable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid1 = valid_q[0];
    assign out_valid2 = valid_q[1];
    assign out_data1  = valid_q[0] ? mem_q[0][rd_ptr_q[0]] : '0;
    assign out_data2  = valid_q[1] ? mem_q[1][rd_ptr_q[1]] : '0;

`ifdef DEMUX_XFER_COUNT_EN
    logic [15:0] xfer_q [2];
    logic [15:0] xfer_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            xfer_d[i] = pop[i] ? xfer_q[i] + 16'd1 : xfer_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_q <= '{default: '0};
        end else begin
            xfer_q <= xfer_d;
        end
    end

    assign xfer_count1 = xfer_q[0];
    assign xfer_count2 = xfer_q[1];
`endif

endmodule
